sigmf_bwd: RTL

- Backward-pass companion to the forward sigmoid activation. Computes the backprop delta for a sigmoid neuron from the stored activation y and an incoming error or target.
- Formula: delta = e * y * (1 - y).
- Sits between the output-error/weight-transpose path and the weight-update engine.
- Uses one shared Q8.24 multiplier over a small FSM, with valid/ready handshakes on both sides.

---
 rtl/sigmf_bwd_pkg.sv | 20 ++
 rtl/sigmf_bwd_if.sv | 28 ++
 rtl/sigmf_bwd_qmul.sv | 19 +
 rtl/sigmf_bwd.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/sigmf_bwd_pkg.sv
// Shared constants and FSM encoding for the sigmoid backward-pass block.
// Q8.24 signed fixed point throughout.
package sigmf_bwd_pkg;

    localparam int unsigned DWIDTH = 32;
    localparam int unsigned FRAC   = 24;
    localparam int unsigned CNTW   = 16;

    localparam logic signed [DWIDTH-1:0] ONE  = 32'sh0100_0000;
    localparam logic signed [DWIDTH-1:0] QMAX = 32'sh7FFF_FFFF;
    localparam logic signed [DWIDTH-1:0] QMIN = 32'sh8000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul1 = 2'd1,
        StMul2 = 2'd2,
        StHold = 2'd3
    } state_e;

endpackage

// File: rtl/sigmf_bwd_if.sv
// Sample-in / delta-out stream bundle for sigmf_bwd.
// The slave modport is the block's view; master is the surrounding datapath.
interface sigmf_bwd_if;
    import sigmf_bwd_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic              mode_out;
    logic [DWIDTH-1:0] y_in;
    logic [DWIDTH-1:0] err_in;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] delta_out;
    logic              out_last;
    logic [CNTW-1:0]   out_cnt;

    modport slave (
        input  in_valid, in_last, mode_out, y_in, err_in, out_ready,
        output in_ready, out_valid, delta_out, out_last, out_cnt
    );

    modport master (
        output in_valid, in_last, mode_out, y_in, err_in, out_ready,
        input  in_ready, out_valid, delta_out, out_last, out_cnt
    );

endinterface

// File: rtl/sigmf_bwd_qmul.sv
// Combinational signed Q8.24 multiply; keeps product bits [FRAC+DWIDTH-1:FRAC],
// which truncates toward -inf.
module sigmf_bwd_qmul
    import sigmf_bwd_pkg::*;
(
    input  logic signed [DWIDTH-1:0] a,
    input  logic signed [DWIDTH-1:0] b,
    output logic signed [DWIDTH-1:0] p
);

    logic signed [2*DWIDTH-1:0] prod;
    logic                       unused_bits;

    assign prod        = a * b;
    assign p           = prod[FRAC+DWIDTH-1:FRAC];
    // Callers guarantee the kept slice cannot overflow, so the dropped bits carry no information.
    assign unused_bits = ^{prod[2*DWIDTH-1:FRAC+DWIDTH], prod[FRAC-1:0]};

endmodule

// File: rtl/sigmf_bwd.sv
// Sigmoid backprop delta: delta = e * y * (1 - y), two passes through one
// shared Q8.24 multiplier sequenced by a four-state FSM.
module sigmf_bwd
    import sigmf_bwd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    sigmf_bwd_if.slave bus
);

    state_e state_q, state_d;

    logic signed [DWIDTH-1:0] y_q, y_d;
    logic signed [DWIDTH-1:0] e_q, e_d;
    logic signed [DWIDTH-1:0] p_q, p_d;
    logic signed [DWIDTH-1:0] delta_q, delta_d;
    logic                     last_q, last_d;
    logic                     out_last_q, out_last_d;
    logic                     out_valid_q, out_valid_d;
    logic                     in_ready_q, in_ready_d;
    logic [CNTW-1:0]          cnt_q, cnt_d;

    logic signed [DWIDTH-1:0] y_clamp;
    logic signed [DWIDTH-1:0] e_cap;
    logic signed [DWIDTH:0]   diff;
    logic signed [DWIDTH-1:0] mul_a, mul_b, mul_p;
    logic                     accept;

    // in_ready is registered so it stays low through reset and rises one clock after release.
    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        y_clamp = $signed(bus.y_in);
        if ($signed(bus.y_in) < 0) begin
            y_clamp = '0;
        end else if ($signed(bus.y_in) > ONE) begin
            y_clamp = ONE;
        end

        diff  = $signed({bus.err_in[DWIDTH-1], bus.err_in}) -
                $signed({y_clamp[DWIDTH-1], y_clamp});
        e_cap = $signed(bus.err_in);
        if (bus.mode_out) begin
            if (diff[DWIDTH] != diff[DWIDTH-1]) begin
                e_cap = diff[DWIDTH] ? QMIN : QMAX;
            end else begin
                e_cap = diff[DWIDTH-1:0];
            end
        end
    end

    // Operand mux: MUL1 forms y*(1-y), every other state presents p*e.
    always_comb begin
        mul_a = p_q;
        mul_b = e_q;
        if (state_q == StMul1) begin
            mul_a = y_q;
            mul_b = ONE - y_q;
        end
    end

    sigmf_bwd_qmul u_qmul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        e_d         = e_q;
        p_d         = p_q;
        delta_d     = delta_q;
        last_d      = last_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        cnt_d       = cnt_q;

        case (state_q)
            StIdle: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    y_d        = y_clamp;
                    e_d        = e_cap;
                    last_d     = bus.in_last;
                    in_ready_d = 1'b0;
                    state_d    = StMul1;
                end
            end
            StMul1: begin
                p_d     = mul_p;
                state_d = StMul2;
            end
            StMul2: begin
                delta_d     = mul_p;
                out_last_d  = last_q;
                out_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNTW'(1);
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            y_q         <= '0;
            e_q         <= '0;
            p_q         <= '0;
            delta_q     <= '0;
            last_q      <= 1'b0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            e_q         <= e_d;
            p_q         <= p_d;
            delta_q     <= delta_d;
            last_q      <= last_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.delta_out = delta_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_cnt   = cnt_q;

endmodule
